// File: rtl/io_out.sv
`default_nettype none
// =============================================================================
// Module      : io_out
// Description : Memory-mapped output port that queues core writes to PORT_ADDR
//               in a small FIFO and hands them to an external ready/valid sink.
// Revision    : 1.0
// =============================================================================
module io_out #(
    parameter int          DEPTH     = 4,
    parameter logic [4:0]  PORT_ADDR = 5'd31
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  logic [4:0]                 rd_addr_i,
    input  logic [7:0]                 wd_data_i,
    output logic                       stall_o,
    output logic [7:0]                 ext_data_o,
    output logic                       ext_valid_o,
    input  logic                       ext_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL_COUNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          drop_q,   drop_d;

    logic w_full;
    logic w_empty;
    logic w_port_wr;
    logic w_push;
    logic w_pop;

    // Flags come from registered occupancy only, so stall_o never sees the
    // same-cycle write strobe or ready.
    assign w_full    = (count_q == C_FULL_COUNT);
    assign w_empty   = (count_q == '0);
    assign w_port_wr = rst_ni & wr_en_i & (rd_addr_i == PORT_ADDR);
    assign w_push    = w_port_wr & ~w_full;
    assign w_pop     = rst_ni & ~w_empty & ext_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q | (w_port_wr & w_full);
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is left uncleared on reset; empty masking hides stale bytes.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wd_data_i;
        end
    end

    assign stall_o     = w_full;
    assign ext_valid_o = ~w_empty;
    assign ext_data_o  = w_empty ? 8'd0 : mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign drop_o      = drop_q;

endmodule
`default_nettype wire
